// File: rtl/gppm_pkg.sv
// gppm_pkg: shared ALU op encoding and widths for the gppm pipeline
package gppm_pkg;
  localparam int FUNC_W = 4;
  typedef enum logic [FUNC_W-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_func_e;
endpackage

// File: rtl/gppm_pipe_if.sv
// gppm_pipe_if: command and result handshake bundle of gppm_pipe
interface gppm_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  import gppm_pkg::*;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic              wdsrc;
  logic [FUNC_W-1:0] func;
  logic [DATA_W-1:0] constant;
  logic              alusrc;
  logic [DATA_W-1:0] aluconst;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [DATA_W-1:0] res_rdata1;
  logic              res_zero;
  modport master (
    output cmd_valid, raddr1, raddr2, wen, waddr, wdsrc, func, constant, alusrc, aluconst, res_ready,
    input  cmd_ready, res_valid, res_data, res_rdata1, res_zero
  );
  modport slave (
    input  cmd_valid, raddr1, raddr2, wen, waddr, wdsrc, func, constant, alusrc, aluconst, res_ready,
    output cmd_ready, res_valid, res_data, res_rdata1, res_zero
  );
endinterface

// File: rtl/gppm_alu.sv
// gppm_alu: combinational ALU; unused op codes yield zero
module gppm_alu
  import gppm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [FUNC_W-1:0] func,
  output logic [DATA_W-1:0] res,
  output logic              is_zero
);
  localparam int SH_W = $clog2(DATA_W);
  logic [SH_W-1:0] shamt;
  // op select; shifts use only the low log2(DATA_W) bits of b
  always_comb begin
    shamt = b[SH_W-1:0];
    res   = '0;
    case (func)
      ALU_ADD:   res = a + b;
      ALU_SUB:   res = a - b;
      ALU_AND:   res = a & b;
      ALU_OR:    res = a | b;
      ALU_XOR:   res = a ^ b;
      ALU_SLL:   res = a << shamt;
      ALU_SRL:   res = a >> shamt;
      ALU_SRA:   res = $unsigned($signed(a) >>> shamt);
      ALU_SLT:   res = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  res = {{(DATA_W-1){1'b0}}, a < b};
      ALU_PASSB: res = b;
      default:   res = '0;
    endcase
    is_zero = res == '0;
  end
endmodule

// File: rtl/gppm_pipe.sv
// gppm_pipe: two-stage regfile+ALU pipeline; GPPM_BYPASS_EN selects S1 forwarding instead of hazard stalls
module gppm_pipe
  import gppm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input logic      clk,
  input logic      rst_n,
  gppm_pipe_if.slave bus
);
  localparam int ADDR_W = $clog2(NREGS);
  logic [DATA_W-1:0] rf [NREGS];
  logic              s1_valid, s1_wen, s1_wdsrc;
  logic [ADDR_W-1:0] s1_waddr;
  logic [FUNC_W-1:0] s1_func;
  logic [DATA_W-1:0] s1_a, s1_b, s1_const;
  logic              s2_valid, s2_zero;
  logic [DATA_W-1:0] s2_data, s2_rdata1;
  logic [DATA_W-1:0] alu_res, s1_wdata, op_a, op_b;
  logic              alu_zero, s1_adv, hz1, hz2, ready, accept;
  gppm_alu #(.DATA_W(DATA_W)) u_alu (
    .a(s1_a), .b(s1_b), .func(s1_func), .res(alu_res), .is_zero(alu_zero)
  );
  // operand fetch, hazard detection and handshake control
  always_comb begin
    s1_wdata = s1_wdsrc ? alu_res : s1_const;
    s1_adv   = s1_valid && (!s2_valid || bus.res_ready);
    hz1      = s1_valid && s1_wen && s1_waddr == bus.raddr1;
    hz2      = s1_valid && s1_wen && !bus.alusrc && s1_waddr == bus.raddr2;
`ifdef GPPM_BYPASS_EN
    op_a     = hz1 ? s1_wdata : rf[bus.raddr1];
    op_b     = bus.alusrc ? bus.aluconst : hz2 ? s1_wdata : rf[bus.raddr2];
    ready    = !s1_valid || s1_adv;
`else
    op_a     = rf[bus.raddr1];
    op_b     = bus.alusrc ? bus.aluconst : rf[bus.raddr2];
    ready    = (!s1_valid || s1_adv) && !hz1 && !hz2;
`endif
    accept   = bus.cmd_valid && ready;
  end
  assign bus.cmd_ready  = ready;
  assign bus.res_valid  = s2_valid;
  assign bus.res_data   = s2_data;
  assign bus.res_rdata1 = s2_rdata1;
  assign bus.res_zero   = s2_zero;
  // S1: capture operands and write-back control on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_wen   <= 1'b0;
      s1_wdsrc <= 1'b0;
      s1_waddr <= '0;
      s1_func  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_const <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_wen   <= bus.wen;
      s1_wdsrc <= bus.wdsrc;
      s1_waddr <= bus.waddr;
      s1_func  <= bus.func;
      s1_a     <= op_a;
      s1_b     <= op_b;
      s1_const <= bus.constant;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end
  // S2: result register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_rdata1 <= '0;
      s2_zero   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid  <= 1'b1;
      s2_data   <= alu_res;
      s2_rdata1 <= s1_a;
      s2_zero   <= alu_zero;
    end else if (bus.res_ready) begin
      s2_valid  <= 1'b0;
    end
  end
  // register file: written once, on the S1->S2 transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (s1_adv && s1_wen) begin
      rf[s1_waddr] <= s1_wdata;
    end
  end
endmodule

// File: tb/tb_gppm_pipe.sv
// tb_gppm_pipe: scoreboard bench for gppm_pipe (32b/16 regs and 8b/4 regs instances)
module tb_gppm_pipe;
  import gppm_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  gppm_pipe_if #(.DATA_W(32), .ADDR_W(4)) b ();
  gppm_pipe_if #(.DATA_W(8),  .ADDR_W(2)) s ();
  gppm_pipe #(.DATA_W(32), .NREGS(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(b.slave));
  gppm_pipe #(.DATA_W(8),  .NREGS(4))  dut_s (.clk(clk), .rst_n(rst_n), .bus(s.slave));
  typedef struct {logic [31:0] d; logic [31:0] r;} exp_t;
  exp_t q[$];
  exp_t qs[$];
  exp_t em, es;
  int checks = 0, errors = 0, stalls = 0, accepts = 0;
  logic [31:0] held;
  bit have;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] ra1, input logic [3:0] ra2, input logic w, input logic [3:0] wa,
                      input logic ws, input logic [3:0] f, input logic [31:0] c, input logic as,
                      input logic [31:0] ac, input logic [31:0] ed, input logic [31:0] er);
    bit ok = 1'b0;
    b.raddr1 = ra1; b.raddr2 = ra2; b.wen = w; b.waddr = wa; b.wdsrc = ws;
    b.func = f; b.constant = c; b.alusrc = as; b.aluconst = ac; b.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b.cmd_ready) begin ok = 1'b1; break; end
      stalls++;
    end
    if (ok) begin
      @(posedge clk);
      q.push_back('{ed, er});
      accepts++;
    end else begin
      checks++; errors++;
      $display("FAIL accept_timeout got cmd_ready=0 want 1");
    end
    #1 b.cmd_valid = 1'b0;
  endtask

  task automatic send_s(input logic [1:0] ra1, input logic [1:0] wa, input logic w, input logic [7:0] c,
                        input logic [7:0] ac, input logic [7:0] ed, input logic [7:0] er);
    bit ok = 1'b0;
    s.raddr1 = ra1; s.raddr2 = 2'd0; s.wen = w; s.waddr = wa; s.wdsrc = 1'b0;
    s.func = ALU_ADD; s.constant = c; s.alusrc = 1'b1; s.aluconst = ac; s.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s.cmd_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      @(posedge clk);
      qs.push_back('{{24'd0, ed}, {24'd0, er}});
    end else begin
      checks++; errors++;
      $display("FAIL small_accept_timeout got cmd_ready=0 want 1");
    end
    #1 s.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && (q.size() != 0 || qs.size() != 0); i++) @(negedge clk);
    chk("drain_pending", 32'(q.size() + qs.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && b.res_valid && b.res_ready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result got %h want none", b.res_data);
      end else begin
        em = q.pop_front();
        chk("res_data", b.res_data, em.d);
        chk("res_rdata1", b.res_rdata1, em.r);
        chk("res_zero", {31'd0, b.res_zero}, {31'd0, em.d == 32'd0});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && s.res_valid && s.res_ready) begin
      if (qs.size() == 0) begin
        checks++; errors++;
        $display("FAIL small_unexpected_result got %h want none", s.res_data);
      end else begin
        es = qs.pop_front();
        chk("small_res_data", {24'd0, s.res_data}, es.d);
        chk("small_res_rdata1", {24'd0, s.res_rdata1}, es.r);
        chk("small_res_zero", {31'd0, s.res_zero}, {31'd0, es.d[7:0] == 8'd0});
      end
    end
  end

  initial begin
    b.cmd_valid = 0; b.raddr1 = 0; b.raddr2 = 0; b.wen = 0; b.waddr = 0; b.wdsrc = 0;
    b.func = 0; b.constant = 0; b.alusrc = 0; b.aluconst = 0; b.res_ready = 1;
    s.cmd_valid = 0; s.raddr1 = 0; s.raddr2 = 0; s.wen = 0; s.waddr = 0; s.wdsrc = 0;
    s.func = 0; s.constant = 0; s.alusrc = 0; s.aluconst = 0; s.res_ready = 1;
    #1;
    chk("rst_res_valid", {31'd0, b.res_valid}, 32'd0);
    chk("rst_res_data", b.res_data, 32'd0);
    chk("rst_res_rdata1", b.res_rdata1, 32'd0);
    chk("rst_res_zero", {31'd0, b.res_zero}, 32'd0);
    chk("rst_small_res_valid", {31'd0, s.res_valid}, 32'd0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, b.cmd_ready}, 32'd1);
    @(posedge clk); #1;
    // write r1=5, then r1+3 with two-cycle latency
    send(0, 0, 1, 1, 0, ALU_ADD, 32'd5, 1, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("latency_t1_valid", {31'd0, b.res_valid}, 32'd0);
    @(negedge clk);
    chk("latency_t2_valid", {31'd0, b.res_valid}, 32'd1);
    @(posedge clk); #1;
    send(1, 0, 0, 0, 0, ALU_ADD, 32'd0, 1, 32'd3, 32'd8, 32'd5);
    wait_drain();
    // back-to-back RAW chain
    stalls = 0;
    send(0, 0, 1, 2, 0, ALU_ADD, 32'h10, 1, 32'd0, 32'd0, 32'd0);
    send(2, 2, 1, 3, 1, ALU_ADD, 32'd0, 0, 32'd0, 32'h20, 32'h10);
    send(3, 0, 0, 0, 0, ALU_ADD, 32'd0, 1, 32'd0, 32'h20, 32'h20);
`ifdef GPPM_BYPASS_EN
    chk("raw_stall_cycles", 32'(stalls), 32'd0);
`else
    chk("raw_stall_cycles", 32'(stalls), 32'd2);
`endif
    wait_drain();
    // backpressure: 4 read-modify-writes of r8..r11 while the consumer stalls
    b.res_ready = 1'b0;
    accepts = 0;
    have = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++)
          send(4'(8 + k), 0, 1, 4'(8 + k), 1, ALU_ADD, 32'd0, 1, 32'(k + 1), 32'(k + 1), 32'd0);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          if (have) chk("stall_res_data_stable", b.res_data, held);
          if (b.res_valid && !have) begin held = b.res_data; have = 1'b1; end
        end
        chk("bp_accepts", 32'(accepts), 32'd2);
        chk("bp_cmd_ready", {31'd0, b.cmd_ready}, 32'd0);
        @(posedge clk);
        #1 b.res_ready = 1'b1;
      end
    join
    wait_drain();
    for (int k = 0; k < 4; k++)
      send(4'(8 + k), 0, 0, 0, 0, ALU_ADD, 32'd0, 1, 32'd0, 32'(k + 1), 32'(k + 1));
    wait_drain();
    // ALU corners and remaining ops
    send(0, 0, 0, 0, 0, ALU_SUB, 32'd0, 1, 32'd1, 32'hFFFFFFFF, 32'd0);
    send(0, 0, 1, 5, 0, ALU_PASSB, 32'h80000000, 1, 32'd7, 32'd7, 32'd0);
    send(5, 0, 0, 0, 0, ALU_SRA, 32'd0, 1, 32'd31, 32'hFFFFFFFF, 32'h80000000);
    send(0, 0, 1, 6, 0, ALU_ADD, 32'hFFFFFFFF, 1, 32'd0, 32'd0, 32'd0);
    send(6, 0, 0, 0, 0, ALU_SLT, 32'd0, 1, 32'd1, 32'd1, 32'hFFFFFFFF);
    send(6, 0, 0, 0, 0, ALU_SLTU, 32'd0, 1, 32'd1, 32'd0, 32'hFFFFFFFF);
    send(1, 0, 0, 0, 0, 4'd12, 32'd0, 1, 32'd5, 32'd0, 32'd5);
    send(5, 0, 0, 0, 0, ALU_XOR, 32'd0, 1, 32'h0F0F, 32'h80000F0F, 32'h80000000);
    send(1, 0, 0, 0, 0, ALU_SLL, 32'd0, 1, 32'h24, 32'h50, 32'd5);
    send(5, 0, 0, 0, 0, ALU_SRL, 32'd0, 1, 32'd4, 32'h08000000, 32'h80000000);
    send(6, 0, 0, 0, 0, ALU_AND, 32'd0, 1, 32'h1234, 32'h1234, 32'hFFFFFFFF);
    send(1, 0, 0, 0, 0, ALU_OR, 32'd0, 1, 32'h30, 32'h35, 32'd5);
    send(1, 5, 0, 0, 0, ALU_SUB, 32'd0, 0, 32'd0, 32'h80000005, 32'd5);
    wait_drain();
    // reset with S1 (write r1=0x77) and S2 both occupied
    b.res_ready = 1'b0;
    send(0, 0, 0, 0, 0, ALU_ADD, 32'd0, 1, 32'h33, 32'h33, 32'd0);
    send(0, 0, 1, 1, 0, ALU_ADD, 32'h77, 1, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", {31'd0, b.res_valid}, 32'd0);
    chk("midrst_res_data", b.res_data, 32'd0);
    q.delete();
    #10 rst_n = 1'b1;
    b.res_ready = 1'b1;
    @(posedge clk); #1;
    send(1, 0, 0, 0, 0, ALU_ADD, 32'd0, 1, 32'd9, 32'd9, 32'd0);
    wait_drain();
    // 8-bit instance: 0xFF + 1 wraps to zero
    send_s(0, 1, 1, 8'hFF, 8'd0, 8'd0, 8'd0);
    send_s(1, 0, 0, 8'd0, 8'd1, 8'd0, 8'hFF);
    wait_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
